// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, FSM state type and byte-enable helper
// for the memory-access stage and its load-alignment sub-module.
package mem_pkg;

    localparam int BE_W = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE,
        ST_BUS
    } state_t;

    // Byte enables for an access of size f3[1:0] at byte offset off.
    function automatic logic [BE_W-1:0] be_of(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic [BE_W-1:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks the byte/half/word at the given offset from a
// read word and sign- or zero-extends it (funct3[2] = 1 zero-extends).
module mem_load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select followed by extension by access size.
    always_comb begin
        byte_sel = rdata[7:0];
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (off)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        case (funct3[1:0])
            2'b00: result = funct3[2]
                ? {{(XLEN-8){1'b0}}, byte_sel}
                : {{(XLEN-8){byte_sel[7]}}, byte_sel};
            2'b01: result = funct3[2]
                ? {{(XLEN-16){1'b0}}, half_sel}
                : {{(XLEN-16){half_sel[15]}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: EX->WB memory stage; pass-through in one cycle, loads/stores
// over a req/ack bus. Optional MEM_MISALIGN_TRAP_EN traps misaligned use.
module mem_lsu
    import mem_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               arst,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    output logic               stall_o,
    input  logic               is_load_i,
    input  logic               is_store_i,
    input  logic [2:0]         funct3_i,
    input  logic [ADDR_W-1:0]  addr_i,
    input  logic [XLEN-1:0]    sdata_i,
    input  logic               reg_wena_i,
    input  logic [RADDR_W-1:0] reg_waddr_i,
    input  logic [XLEN-1:0]    reg_wdata_i,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic [ADDR_W-1:0]  dmem_addr_o,
    output logic [BE_W-1:0]    dmem_be_o,
    output logic [XLEN-1:0]    dmem_wdata_o,
    input  logic               dmem_ack_i,
    input  logic [XLEN-1:0]    dmem_rdata_i,
    output logic               wb_valid_o,
    output logic               wb_wena_o,
    output logic [RADDR_W-1:0] wb_waddr_o,
    output logic [XLEN-1:0]    wb_wdata_o,
    output logic               misalign_o
);

    state_t             state;
    logic [1:0]         ld_off;
    logic [2:0]         ld_f3;
    logic               ld_wena;
    logic [RADDR_W-1:0] ld_waddr;
    logic               mis_q;
    logic [XLEN-1:0]    ld_data;
    logic               is_mem;
    logic               trap_hit;
    logic [1:0]         eff_off;
    logic [XLEN-1:0]    lane_data;

    assign in_ready_o = (state == ST_IDLE);
    assign stall_o    = ~in_ready_o;
    assign misalign_o = mis_q;
    // Both type bits high is illegal and falls back to pass-through.
    assign is_mem     = is_load_i ^ is_store_i;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap_hit = (funct3_i[1:0] == 2'b01 && addr_i[0])
                   || (funct3_i[1] && addr_i[1:0] != 2'b00);
`else
    assign trap_hit = 1'b0;
`endif

    // Offset with the offending low bits cleared for halves and words.
    always_comb begin
        case (funct3_i[1:0])
            2'b00: begin
                eff_off   = addr_i[1:0];
                lane_data = {4{sdata_i[7:0]}};
            end
            2'b01: begin
                eff_off   = {addr_i[1], 1'b0};
                lane_data = {2{sdata_i[15:0]}};
            end
            default: begin
                eff_off   = 2'b00;
                lane_data = sdata_i;
            end
        endcase
    end

    mem_load_align #(
        .XLEN(XLEN)
    ) u_align (
        .rdata  (dmem_rdata_i),
        .off    (ld_off),
        .funct3 (ld_f3),
        .result (ld_data)
    );

    // Stage FSM; bus outputs and writeback record are all registered.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state        <= ST_IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= '0;
            dmem_be_o    <= '0;
            dmem_wdata_o <= '0;
            ld_off       <= '0;
            ld_f3        <= '0;
            ld_wena      <= 1'b0;
            ld_waddr     <= '0;
            wb_valid_o   <= 1'b0;
            wb_wena_o    <= 1'b0;
            wb_waddr_o   <= '0;
            wb_wdata_o   <= '0;
            mis_q        <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            mis_q      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid_i) begin
                        if (!is_mem) begin
                            wb_valid_o <= 1'b1;
                            wb_wena_o  <= reg_wena_i;
                            wb_waddr_o <= reg_waddr_i;
                            wb_wdata_o <= reg_wdata_i;
                        end else if (trap_hit) begin
                            wb_valid_o <= 1'b1;
                            wb_wena_o  <= 1'b0;
                            wb_waddr_o <= reg_waddr_i;
                            wb_wdata_o <= '0;
                            mis_q      <= 1'b1;
                        end else begin
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= is_store_i;
                            dmem_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
                            dmem_be_o    <= be_of(funct3_i, eff_off);
                            dmem_wdata_o <= lane_data;
                            ld_off       <= eff_off;
                            ld_f3        <= funct3_i;
                            ld_wena      <= is_load_i & reg_wena_i
                                          & (|reg_waddr_i);
                            ld_waddr     <= reg_waddr_i;
                            state        <= ST_BUS;
                        end
                    end
                end
                ST_BUS: begin
                    if (dmem_ack_i) begin
                        dmem_req_o <= 1'b0;
                        wb_valid_o <= 1'b1;
                        wb_wena_o  <= ld_wena;
                        wb_waddr_o <= ld_waddr;
                        wb_wdata_o <= dmem_we_o ? '0 : ld_data;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed tests for mem_lsu; inputs change and outputs are
// sampled on the falling clock edge.
module tb_mem_lsu;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        arst;
    logic        in_valid_i, in_ready_o, stall_o;
    logic        is_load_i, is_store_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, sdata_i, reg_wdata_i;
    logic        reg_wena_i;
    logic [4:0]  reg_waddr_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o, wb_wena_o;
    logic [4:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        misalign_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk          (clk),
        .arst         (arst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .stall_o      (stall_o),
        .is_load_i    (is_load_i),
        .is_store_i   (is_store_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .sdata_i      (sdata_i),
        .reg_wena_i   (reg_wena_i),
        .reg_waddr_i  (reg_waddr_i),
        .reg_wdata_i  (reg_wdata_i),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_ack_i   (dmem_ack_i),
        .dmem_rdata_i (dmem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_wena_o    (wb_wena_o),
        .wb_waddr_o   (wb_waddr_o),
        .wb_wdata_o   (wb_wdata_o),
        .misalign_o   (misalign_o)
    );

    task automatic drive(input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [4:0] wa,
                         input logic [31:0] wd);
        in_valid_i  = 1'b1;
        is_load_i   = ld;
        is_store_i  = st;
        funct3_i    = f3;
        addr_i      = a;
        sdata_i     = sd;
        reg_wena_i  = 1'b1;
        reg_waddr_i = wa;
        reg_wdata_i = wd;
    endtask

    task automatic test_reset;
        arst = 1'b1;
        in_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
        funct3_i = '0; addr_i = '0; sdata_i = '0; reg_wena_i = 1'b0;
        reg_waddr_i = '0; reg_wdata_i = '0;
        dmem_ack_i = 1'b0; dmem_rdata_i = '0;
        repeat (2) @(negedge clk);
        vectors++;
        if (in_ready_o !== 1'b1 || stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ready: ready=%b stall=%b want 1/0",
                     in_ready_o, stall_o);
        end
        vectors++;
        if ({dmem_req_o, dmem_we_o, wb_valid_o, wb_wena_o, misalign_o}
            !== 5'b0 || dmem_be_o !== 4'b0 || wb_wdata_o !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outs: req=%b be=%b wbv=%b wd=%h want 0",
                     dmem_req_o, dmem_be_o, wb_valid_o, wb_wdata_o);
        end
        arst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_passthrough;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0, 5'd3, 32'h1234);
        @(negedge clk);
        drive(1'b1, 1'b1, F3_W, 32'h0, 32'h0, 5'd4, 32'h5678);
        vectors++;
        if (wb_valid_o !== 1'b1 || wb_wdata_o !== 32'h1234
            || wb_waddr_o !== 5'd3 || wb_wena_o !== 1'b1
            || dmem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL pass1: v=%b d=%h a=%0d req=%b want 1/1234/3/0",
                     wb_valid_o, wb_wdata_o, wb_waddr_o, dmem_req_o);
        end
        @(negedge clk);
        in_valid_i = 1'b0;
        vectors++;
        if (wb_valid_o !== 1'b1 || wb_wdata_o !== 32'h5678
            || wb_waddr_o !== 5'd4 || dmem_req_o !== 1'b0) begin
            miscompares++;
            $display("FAIL pass2_illegal: v=%b d=%h req=%b want 1/5678/0",
                     wb_valid_o, wb_wdata_o, dmem_req_o);
        end
        @(negedge clk);
        vectors++;
        if (wb_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL pass_pulse: wb_valid=%b want 0", wb_valid_o);
        end
    endtask

    task automatic test_load(input logic [2:0] f3, input logic [31:0] a,
                             input logic [4:0] wa, input logic [31:0] rd,
                             input logic [31:0] exp_addr,
                             input logic [3:0] exp_be,
                             input logic [31:0] exp_d,
                             input logic exp_wena);
        drive(1'b1, 1'b0, f3, a, 32'h0, wa, 32'hDEAD);
        @(negedge clk);
        in_valid_i = 1'b0;
        vectors++;
        if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b0
            || dmem_addr_o !== exp_addr || dmem_be_o !== exp_be
            || stall_o !== 1'b1 || wb_valid_o !== 1'b0) begin
            miscompares++;
            $display("FAIL ld_req f3=%0d: req=%b addr=%h be=%b st=%b want 1/%h/%b/1",
                     f3, dmem_req_o, dmem_addr_o, dmem_be_o, stall_o,
                     exp_addr, exp_be);
        end
        dmem_ack_i = 1'b1;
        dmem_rdata_i = rd;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        vectors++;
        if (wb_valid_o !== 1'b1 || wb_wdata_o !== exp_d
            || wb_wena_o !== exp_wena || wb_waddr_o !== wa
            || dmem_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL ld_wb f3=%0d: v=%b d=%h en=%b req=%b want 1/%h/%b/0",
                     f3, wb_valid_o, wb_wdata_o, wb_wena_o, dmem_req_o,
                     exp_d, exp_wena);
        end
    endtask

    task automatic test_store_wait;
        int stall_cnt = 0;
        drive(1'b0, 1'b1, F3_H, 32'h22, 32'h1234_ABCD, 5'd7, 32'h0);
        @(negedge clk);
        in_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (stall_o === 1'b1) stall_cnt++;
            vectors++;
            if (dmem_req_o !== 1'b1 || dmem_we_o !== 1'b1
                || dmem_addr_o !== 32'h20 || dmem_be_o !== 4'b1100
                || dmem_wdata_o !== 32'hABCD_ABCD) begin
                miscompares++;
                $display("FAIL sh_bus%0d: req=%b we=%b a=%h be=%b wd=%h want 1/1/20/1100/abcdabcd",
                         i, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
                         dmem_wdata_o);
            end
            if (i == 3) dmem_ack_i = 1'b1;
            @(negedge clk);
        end
        dmem_ack_i = 1'b0;
        vectors++;
        if (stall_cnt != 4 || stall_o !== 1'b0) begin
            miscompares++;
            $display("FAIL sh_stall: cycles=%0d now=%b want 4/0",
                     stall_cnt, stall_o);
        end
        vectors++;
        if (wb_valid_o !== 1'b1 || wb_wena_o !== 1'b0) begin
            miscompares++;
            $display("FAIL sh_wb: v=%b en=%b want 1/0",
                     wb_valid_o, wb_wena_o);
        end
    endtask

    task automatic test_misalign;
        drive(1'b1, 1'b0, F3_W, 32'h6, 32'h0, 5'd9, 32'h0);
        @(negedge clk);
        in_valid_i = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        vectors++;
        if (misalign_o !== 1'b1 || dmem_req_o !== 1'b0
            || wb_valid_o !== 1'b1 || wb_wena_o !== 1'b0
            || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL mis_trap: mis=%b req=%b v=%b en=%b want 1/0/1/0",
                     misalign_o, dmem_req_o, wb_valid_o, wb_wena_o);
        end
        @(negedge clk);
`else
        vectors++;
        if (dmem_req_o !== 1'b1 || dmem_addr_o !== 32'h4
            || dmem_be_o !== 4'b1111 || misalign_o !== 1'b0) begin
            miscompares++;
            $display("FAIL mis_force: req=%b a=%h be=%b mis=%b want 1/4/1111/0",
                     dmem_req_o, dmem_addr_o, dmem_be_o, misalign_o);
        end
        dmem_ack_i = 1'b1;
        dmem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        vectors++;
        if (wb_valid_o !== 1'b1 || wb_wdata_o !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL mis_wb: v=%b d=%h want 1/deadbeef",
                     wb_valid_o, wb_wdata_o);
        end
`endif
    endtask

    task automatic test_reset_mid;
        drive(1'b0, 1'b1, F3_W, 32'h10, 32'h55AA_55AA, 5'd2, 32'h0);
        @(negedge clk);
        in_valid_i = 1'b0;
        #2 arst = 1'b1;
        #1;
        vectors++;
        if (dmem_req_o !== 1'b0 || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_async: req=%b ready=%b want 0/1",
                     dmem_req_o, in_ready_o);
        end
        @(negedge clk);
        arst = 1'b0;
        dmem_ack_i = 1'b1;
        @(negedge clk);
        dmem_ack_i = 1'b0;
        vectors++;
        if (wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0
            || in_ready_o !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_late_ack: v=%b req=%b ready=%b want 0/0/1",
                     wb_valid_o, dmem_req_o, in_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load(F3_B,  32'h103, 5'd5, 32'h80FF_FF00,
                  32'h100, 4'b1000, 32'hFFFF_FF80, 1'b1);
        test_load(F3_BU, 32'h103, 5'd5, 32'h80FF_FF00,
                  32'h100, 4'b1000, 32'h0000_0080, 1'b1);
        test_load(F3_H,  32'h202, 5'd6, 32'h8001_7FFF,
                  32'h200, 4'b1100, 32'hFFFF_8001, 1'b1);
        test_load(F3_HU, 32'h200, 5'd6, 32'h8001_F00F,
                  32'h200, 4'b0011, 32'h0000_F00F, 1'b1);
        test_load(F3_B,  32'h301, 5'd8, 32'h1234_5678,
                  32'h300, 4'b0010, 32'h0000_0056, 1'b1);
        test_load(F3_W,  32'h40, 5'd0, 32'hCAFE_F00D,
                  32'h40, 4'b1111, 32'hCAFE_F00D, 1'b0);
        test_store_wait();
        test_misalign();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Parametrised memory-access stage between EX and WB. Accepts one instruction per handshake from EX and passes non-memory results through in one cycle. Runs loads and stores on a stalling data-memory bus with a request/acknowledge handshake. Generates byte enables, aligns and sign- or zero-extends load data, and returns a registered writeback record to WB.

## Interface
- XLEN, 32: data/register width; 32 only in this generation, parameter kept for width checks
- ADDR_W, 32: byte-address width
- RADDR_W, 5: register-file address width
- clk  in  1  clock, rising edge
- arst  in  1  reset, asynchronous, active-high
- in_valid_i  in  1  EX presents an instruction
- in_ready_o  out  1  stage accepts this cycle
- stall_o  out  1  equals ~in_ready_o, to the hazard unit
- is_load_i / is_store_i  in  1 each  access type; both low means pass-through; both high is illegal, treated as pass-through
- funct3_i  in  3  access size/sign (RV32I load/store encoding)
- addr_i  in  ADDR_W  effective byte address
- sdata_i  in  XLEN  store data, in the low bits
- reg_wena_i  in  1  register write enable
- reg_waddr_i  in  RADDR_W  destination register
- reg_wdata_i  in  XLEN  ALU result for non-load instructions
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  ADDR_W  word address (bits [1:0] = 0)
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  XLEN  lane-shifted store data
- dmem_ack_i  in  1  bus completes the request this cycle
- dmem_rdata_i  in  XLEN  read word, valid with ack
- wb_valid_o  out  1  one-cycle writeback pulse
- wb_wena_o  out  1  register write enable to WB
- wb_waddr_o  out  RADDR_W  destination to WB
- wb_wdata_o  out  XLEN  result to WB
- misalign_o  out  1  misaligned-access pulse (MEM_MISALIGN_TRAP_EN only)

## Operation
- FSM states:
  - IDLE: in_ready_o = 1.
  - BUS: dmem_req_o = 1; all dmem_* outputs held stable.
- IDLE, in_valid_i, pass-through: register reg_* into wb_* and pulse wb_valid_o the next cycle; stay in IDLE.
- IDLE, in_valid_i, load/store: latch the request and enter BUS.
- BUS, dmem_ack_i = 1: return to IDLE.
  - Load: capture the extended data into wb_wdata_o and pulse wb_valid_o next cycle. wb_wena_o = reg_wena_i latched, forced to 0 when reg_waddr_i = 0.
  - Store: pulse wb_valid_o next cycle with wb_wena_o = 0.
- dmem_ack_i is ignored outside BUS.
- Byte enables and lanes, with off = addr[1:0]:
  - byte (funct3[1:0] = 00): be = 0001 << off; data byte replicated to all four lanes.
  - half (01): be = 0011 << (2·addr[1]); data half replicated to both halves.
  - word (10): be = 1111.
  - funct3[1:0] = 11: treated as word.
- Load extension: select the byte/half at off. funct3[2] = 0 sign-extends, 1 zero-extends.
- Misalignment: half with addr[0] = 1, or word with addr[1:0] ≠ 0.

## Timing
- Reset outputs: every output 0 except in_ready_o = 1 and stall_o = 0. FSM goes to IDLE.
- Pass-through latency: 1 cycle, throughput 1 per cycle.
- Memory access latency: 2 cycles when ack arrives in the first BUS cycle, plus 1 per wait cycle. No back-to-back accesses; minimum 2 cycles per access.
- dmem_req_o is registered; it first rises the cycle after acceptance.
- Reset asserted mid-access: dmem_req_o drops asynchronously, no wb_valid_o is produced, and a late ack after reset release is ignored.
- in_valid_i while in BUS: not accepted; EX must hold its inputs.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: a misaligned access issues no bus request, stays in IDLE, and pulses misalign_o together with wb_valid_o (wb_wena_o = 0) the next cycle.
- MEM_MISALIGN_TRAP_EN undefined: offending low address bits are forced to 0 (half clears bit 0, word clears [1:0]). The access proceeds normally and misalign_o is tied to 0.

## Structure
- Shared package mem_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU
  - state enum: ST_IDLE, ST_BUS
  - byte-enable width constant BE_W = 4
- One combinational sub-module, mem_load_align: rdata, off, funct3 in; extended XLEN result out. Shared with any future forwarding path.

## Test plan
- Pass-through: reg_wdata_i = 0x1234, waddr = 3, no memory access -> next cycle wb_valid_o = 1, wb_wdata_o = 0x1234, wb_waddr_o = 3; no dmem_req_o.
- LB at addr 0x103, rdata 0x80FF_FF00, zero-wait ack -> be 1000, dmem_addr_o = 0x100, wb_wdata_o = 0xFFFF_FF80 two cycles after accept; LBU of the same access gives 0x0000_0080.
- SH at addr 0x22, sdata 0xABCD, ack after 3 wait cycles -> be 1100, wdata 0xABCD_ABCD, stall_o high for 4 cycles, wb_wena_o = 0.
- Load to x0 -> wb_valid_o = 1, wb_wena_o = 0.
- LW at 0x6 -> MEM_MISALIGN_TRAP_EN defined: misalign_o pulse, no req. Undefined: access at 0x4, be 1111.
- arst pulsed during BUS with ack arriving after release -> no wb_valid_o; in_ready_o = 1 immediately after reset.
